// File: rtl/input_conditioner_if.sv
// Pin-side and fabric-side signals of the input conditioner.
// The conditioner connects to the slave modport; the pin driver and consumer connect to the master modport.
interface input_conditioner_if #(
    parameter int NUM_KEY = 2,
    parameter int NUM_SW  = 8
);
    logic [NUM_KEY-1:0] key_n_in;
    logic [NUM_SW-1:0]  sw_in;
    logic [NUM_KEY-1:0] key_flag_ack;
    logic [NUM_KEY-1:0] key_db_n;
    logic [NUM_SW-1:0]  sw_db;
    logic [NUM_KEY-1:0] key_press_pulse;
    logic [NUM_KEY-1:0] key_press_flag;
    logic               sw_change_pulse;

    modport master (
        output key_n_in, sw_in, key_flag_ack,
        input  key_db_n, sw_db, key_press_pulse, key_press_flag, sw_change_pulse
    );

    modport slave (
        input  key_n_in, sw_in, key_flag_ack,
        output key_db_n, sw_db, key_press_pulse, key_press_flag, sw_change_pulse
    );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: 2-flop sync + per-bit debounce of keys/switches, with press/change pulses and sticky press flags.
// Latency: pin sampled at edge P -> debounced level at edge P+1+STABLE_CYCLES, pulses one edge later.
// Backpressure: none; pins are free-running levels, sticky flags hold until the per-key ack.
module input_conditioner #(
    parameter int NUM_KEY       = 2,
    parameter int NUM_SW        = 8,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input_conditioner_if.slave   io
);
    localparam int N  = NUM_KEY + NUM_SW;
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);
    // Keys occupy the low bits and idle high (released); switches idle low.
    localparam logic [N-1:0] RST_VAL = {{NUM_SW{1'b0}}, {NUM_KEY{1'b1}}};

    logic [N-1:0]       sync1;
    logic [N-1:0]       sync2;
    logic [N-1:0]       db;
    logic [N-1:0]       db_prev;
    logic [CW-1:0]      cnt [N];
    logic [NUM_KEY-1:0] press_pulse;
    logic [NUM_KEY-1:0] press_flag;
    logic               change_pulse;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1        <= RST_VAL;
            sync2        <= RST_VAL;
            db           <= RST_VAL;
            db_prev      <= RST_VAL;
            press_pulse  <= '0;
            press_flag   <= '0;
            change_pulse <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= {io.sw_in, io.key_n_in};
            sync2   <= sync1;
            db_prev <= db;

            // Any sample agreeing with the current level restarts the count.
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERM) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end

            press_pulse  <= db_prev[NUM_KEY-1:0] & ~db[NUM_KEY-1:0];
            change_pulse <= (db_prev[N-1:NUM_KEY] != db[N-1:NUM_KEY]);
            // A press arriving with the ack keeps the flag set.
            press_flag   <= press_pulse | (press_flag & ~io.key_flag_ack);
        end
    end

    assign io.key_db_n        = db[NUM_KEY-1:0];
    assign io.sw_db           = db[N-1:NUM_KEY];
    assign io.key_press_pulse = press_pulse;
    assign io.key_press_flag  = press_flag;
    assign io.sw_change_pulse = change_pulse;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed scenarios plus a randomized run against a sliding-window debounce model.
module tb_input_conditioner;
    localparam int K = 2;
    localparam int W = 8;
    localparam int N = K + W;
    localparam int S = 16;
    localparam logic [N-1:0] RSTV = {{W{1'b0}}, {K{1'b1}}};

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    input_conditioner_if #(.NUM_KEY(K), .NUM_SW(W)) io ();

    input_conditioner #(.NUM_KEY(K), .NUM_SW(W), .STABLE_CYCLES(S)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .io    (io)
    );

    always #5 Clk = ~Clk;

    // Reference: a level follows once the synchronized input has disagreed with it on each of the last S edges.
    logic [N-1:0] m_s1, m_s2, m_db, m_prev;
    logic [N-1:0] win[$];
    logic [K-1:0] m_kpulse, m_flag;
    logic         m_swpulse;

    task automatic tick();
        logic [N-1:0] nb;
        @(posedge Clk);
        if (Reset) begin
            m_s1 = RSTV; m_s2 = RSTV; m_db = RSTV; m_prev = RSTV;
            win.delete();
            m_kpulse = '0; m_flag = '0; m_swpulse = 1'b0;
        end else begin
            nb = m_db;
            win.push_back(m_s2);
            if (win.size() > S) void'(win.pop_front());
            for (int b = 0; b < N; b++) begin
                bit all_diff;
                all_diff = (win.size() == S);
                foreach (win[k]) if (win[k][b] == m_db[b]) all_diff = 1'b0;
                if (all_diff) nb[b] = ~m_db[b];
            end
            m_flag    = m_kpulse | (m_flag & ~io.key_flag_ack);
            m_kpulse  = m_prev[K-1:0] & ~m_db[K-1:0];
            m_swpulse = (m_prev[N-1:K] != m_db[N-1:K]);
            m_prev    = m_db;
            m_db      = nb;
            m_s2      = m_s1;
            m_s1      = {io.sw_in, io.key_n_in};
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; io.key_n_in = 2'b00; io.sw_in = 8'hFF; io.key_flag_ack = 2'b00;
        tick(); tick();
        checks++; if (io.key_db_n !== 2'b11) begin failures++; $display("FAIL reset_key_db got=%b exp=11", io.key_db_n); end
        checks++; if (io.sw_db !== 8'h00) begin failures++; $display("FAIL reset_sw_db got=%h exp=00", io.sw_db); end
        checks++; if (io.key_press_pulse !== 2'b00) begin failures++; $display("FAIL reset_kpulse got=%b exp=00", io.key_press_pulse); end
        checks++; if (io.key_press_flag !== 2'b00) begin failures++; $display("FAIL reset_kflag got=%b exp=00", io.key_press_flag); end
        checks++; if (io.sw_change_pulse !== 1'b0) begin failures++; $display("FAIL reset_swpulse got=%b exp=0", io.sw_change_pulse); end
        Reset = 1'b0;
        tick(); repeat (16) tick();
        checks++; if (io.key_db_n !== 2'b11) begin failures++; $display("FAIL post_reset_key_early got=%b exp=11", io.key_db_n); end
        checks++; if (io.sw_db !== 8'h00) begin failures++; $display("FAIL post_reset_sw_early got=%h exp=00", io.sw_db); end
        tick();
        checks++; if (io.key_db_n !== 2'b00) begin failures++; $display("FAIL post_reset_key_db got=%b exp=00", io.key_db_n); end
        checks++; if (io.sw_db !== 8'hFF) begin failures++; $display("FAIL post_reset_sw_db got=%h exp=ff", io.sw_db); end
        tick();
        checks++; if (io.key_press_pulse !== 2'b11) begin failures++; $display("FAIL post_reset_kpulse got=%b exp=11", io.key_press_pulse); end
        checks++; if (io.sw_change_pulse !== 1'b1) begin failures++; $display("FAIL post_reset_swpulse got=%b exp=1", io.sw_change_pulse); end
        tick();
        checks++; if (io.key_press_pulse !== 2'b00) begin failures++; $display("FAIL post_reset_kpulse_end got=%b exp=00", io.key_press_pulse); end
        checks++; if (io.sw_change_pulse !== 1'b0) begin failures++; $display("FAIL post_reset_swpulse_end got=%b exp=0", io.sw_change_pulse); end
        checks++; if (io.key_press_flag !== 2'b11) begin failures++; $display("FAIL post_reset_kflag got=%b exp=11", io.key_press_flag); end
    endtask

    task automatic test_release();
        io.key_n_in = 2'b11; io.key_flag_ack = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (io.key_press_pulse !== 2'b00) begin failures++; $display("FAIL release_kpulse cyc=%0d got=%b exp=00", i, io.key_press_pulse); end
        end
        io.key_flag_ack = 2'b00;
        checks++; if (io.key_db_n !== 2'b11) begin failures++; $display("FAIL release_key_db got=%b exp=11", io.key_db_n); end
        checks++; if (io.key_press_flag !== 2'b00) begin failures++; $display("FAIL release_kflag got=%b exp=00", io.key_press_flag); end
    endtask

    task automatic test_key_press();
        io.key_n_in = 2'b10;
        tick(); repeat (16) tick();
        checks++; if (io.key_db_n !== 2'b11) begin failures++; $display("FAIL press_early got=%b exp=11", io.key_db_n); end
        tick();
        checks++; if (io.key_db_n !== 2'b10) begin failures++; $display("FAIL press_key_db got=%b exp=10", io.key_db_n); end
        tick();
        checks++; if (io.key_press_pulse !== 2'b01) begin failures++; $display("FAIL press_pulse got=%b exp=01", io.key_press_pulse); end
        tick();
        checks++; if (io.key_press_pulse !== 2'b00) begin failures++; $display("FAIL press_pulse_width got=%b exp=00", io.key_press_pulse); end
        checks++; if (io.key_press_flag !== 2'b01) begin failures++; $display("FAIL press_flag got=%b exp=01", io.key_press_flag); end
    endtask

    task automatic test_flag_ack();
        io.key_flag_ack = 2'b01; tick(); io.key_flag_ack = 2'b00;
        checks++; if (io.key_press_flag !== 2'b00) begin failures++; $display("FAIL ack_clear got=%b exp=00", io.key_press_flag); end
        io.key_flag_ack = 2'b01; tick(); io.key_flag_ack = 2'b00;
        checks++; if (io.key_press_flag !== 2'b00) begin failures++; $display("FAIL ack_noop got=%b exp=00", io.key_press_flag); end
        io.key_n_in = 2'b11; repeat (20) tick();
        io.key_n_in = 2'b10;
        tick(); repeat (17) tick(); tick();
        checks++; if (io.key_press_pulse !== 2'b01) begin failures++; $display("FAIL ack_race_pulse got=%b exp=01", io.key_press_pulse); end
        io.key_flag_ack = 2'b01; tick(); io.key_flag_ack = 2'b00;
        checks++; if (io.key_press_flag !== 2'b01) begin failures++; $display("FAIL ack_race_set_wins got=%b exp=01", io.key_press_flag); end
        tick();
        checks++; if (io.key_press_flag !== 2'b01) begin failures++; $display("FAIL ack_race_hold got=%b exp=01", io.key_press_flag); end
    endtask

    task automatic test_bounce();
        io.key_n_in = 2'b11; io.key_flag_ack = 2'b01; repeat (20) tick(); io.key_flag_ack = 2'b00;
        for (int i = 0; i < 60; i++) begin
            io.key_n_in[0] = ((i / 5) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            checks++; if (io.key_db_n !== 2'b11 || io.key_press_pulse !== 2'b00) begin
                failures++; $display("FAIL bounce_quiet cyc=%0d got db=%b pulse=%b exp db=11 pulse=00", i, io.key_db_n, io.key_press_pulse);
            end
        end
        io.key_n_in[0] = 1'b0;
        tick(); repeat (16) tick();
        checks++; if (io.key_db_n !== 2'b11) begin failures++; $display("FAIL bounce_settle_early got=%b exp=11", io.key_db_n); end
        tick();
        checks++; if (io.key_db_n !== 2'b10) begin failures++; $display("FAIL bounce_settle got=%b exp=10", io.key_db_n); end
        tick();
        checks++; if (io.key_press_pulse !== 2'b01) begin failures++; $display("FAIL bounce_pulse got=%b exp=01", io.key_press_pulse); end
        io.key_n_in = 2'b11;
        for (int i = 0; i < 25; i++) begin
            tick();
            checks++; if (io.key_press_pulse !== 2'b00) begin failures++; $display("FAIL bounce_release_pulse cyc=%0d got=%b exp=00", i, io.key_press_pulse); end
        end
        checks++; if (io.key_db_n !== 2'b11) begin failures++; $display("FAIL bounce_release_db got=%b exp=11", io.key_db_n); end
    endtask

    task automatic test_sw_change();
        io.sw_in = 8'h00; repeat (20) tick();
        io.sw_in = 8'hA5;
        tick(); repeat (16) tick();
        checks++; if (io.sw_db !== 8'h00) begin failures++; $display("FAIL sw_early got=%h exp=00", io.sw_db); end
        tick();
        checks++; if (io.sw_db !== 8'hA5) begin failures++; $display("FAIL sw_db got=%h exp=a5", io.sw_db); end
        tick();
        checks++; if (io.sw_change_pulse !== 1'b1) begin failures++; $display("FAIL sw_pulse got=%b exp=1", io.sw_change_pulse); end
        tick();
        checks++; if (io.sw_change_pulse !== 1'b0) begin failures++; $display("FAIL sw_pulse_single got=%b exp=0", io.sw_change_pulse); end
        io.sw_in = 8'hAD; repeat (10) tick();
        io.sw_in = 8'hA5;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++; if (io.sw_db !== 8'hA5 || io.sw_change_pulse !== 1'b0) begin
                failures++; $display("FAIL sw_glitch cyc=%0d got db=%h pulse=%b exp db=a5 pulse=0", i, io.sw_db, io.sw_change_pulse);
            end
        end
    endtask

    task automatic test_reset_midcount();
        io.key_n_in = 2'b10;
        tick(); repeat (9) tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        checks++; if (io.key_db_n !== 2'b11 || io.sw_db !== 8'h00) begin
            failures++; $display("FAIL midreset_levels got key=%b sw=%h exp key=11 sw=00", io.key_db_n, io.sw_db);
        end
        checks++; if (io.key_press_pulse !== 2'b00 || io.key_press_flag !== 2'b00 || io.sw_change_pulse !== 1'b0) begin
            failures++; $display("FAIL midreset_pulses got kp=%b kf=%b sp=%b exp 00 00 0", io.key_press_pulse, io.key_press_flag, io.sw_change_pulse);
        end
        tick(); repeat (16) tick();
        checks++; if (io.key_db_n !== 2'b11) begin failures++; $display("FAIL midreset_restart_early got=%b exp=11", io.key_db_n); end
        tick();
        checks++; if (io.key_db_n !== 2'b10) begin failures++; $display("FAIL midreset_restart got=%b exp=10", io.key_db_n); end
        checks++; if (io.sw_db !== 8'hA5) begin failures++; $display("FAIL midreset_sw got=%h exp=a5", io.sw_db); end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                io.key_n_in = io.key_n_in ^ K'($urandom_range(0, 3));
                io.sw_in    = io.sw_in ^ W'($urandom_range(0, 255));
                hold = $urandom_range(1, 40);
            end
            hold--;
            io.key_flag_ack = ($urandom_range(0, 3) == 0) ? K'($urandom_range(0, 3)) : 2'b00;
            Reset = ($urandom_range(0, 599) == 0);
            tick();
            checks++; if (io.key_db_n !== m_db[K-1:0]) begin failures++; $display("FAIL rnd_key_db cyc=%0d got=%b exp=%b", c, io.key_db_n, m_db[K-1:0]); end
            checks++; if (io.sw_db !== m_db[N-1:K]) begin failures++; $display("FAIL rnd_sw_db cyc=%0d got=%h exp=%h", c, io.sw_db, m_db[N-1:K]); end
            checks++; if (io.key_press_pulse !== m_kpulse) begin failures++; $display("FAIL rnd_kpulse cyc=%0d got=%b exp=%b", c, io.key_press_pulse, m_kpulse); end
            checks++; if (io.key_press_flag !== m_flag) begin failures++; $display("FAIL rnd_kflag cyc=%0d got=%b exp=%b", c, io.key_press_flag, m_flag); end
            checks++; if (io.sw_change_pulse !== m_swpulse) begin failures++; $display("FAIL rnd_swpulse cyc=%0d got=%b exp=%b", c, io.sw_change_pulse, m_swpulse); end
        end
        Reset = 1'b0; io.key_flag_ack = 2'b00;
    endtask

    initial begin
        io.key_n_in = 2'b11; io.sw_in = 8'h00; io.key_flag_ack = 2'b00;
        test_reset();
        test_release();
        test_key_press();
        test_flag_ack();
        test_bounce();
        test_sw_change();
        test_reset_midcount();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
